region_scanner: RTL and testbench
=================================

Name: region_scanner

Overview:
- Read-side counterpart to the pixel-write path. On a start pulse, the block scans a rectangular region of the shadow framebuffer in raster order, one read per cycle.
- It reports whether any pixel in the region differs from the background colour, where the first such pixel is, and how many there are.
- Game logic uses it for collision and occupancy checks. It sits beside the shadow framebuffer RAM read port.

Parameters:
- X_WIDTH, 8, x coordinate width.
- Y_WIDTH, 7, y coordinate width.
- COLOUR_WIDTH, 3, pixel colour width.
- READ_LATENCY, 1, RAM read latency in cycles. Legal values are 1 and 2.
- BG_COLOUR, 0, background colour. Pixels equal to this value do not count as hits.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches bounds and begins a scan.
- lowerXBound  in  X_WIDTH  inclusive left bound.
- upperXBound  in  X_WIDTH  inclusive right bound.
- lowerYBound  in  Y_WIDTH  inclusive top bound.
- upperYBound  in  Y_WIDTH  inclusive bottom bound.
- rdX  out  X_WIDTH  RAM read address, x.
- rdY  out  Y_WIDTH  RAM read address, y.
- rdEn  out  1  read strobe.
- rdColour  in  COLOUR_WIDTH  RAM read data, valid READ_LATENCY cycles after rdEn.
- done  out  1  high when idle or the result is valid.
- hit  out  1  at least one non-background pixel found.
- hitX  out  X_WIDTH  x of the first hit in raster order.
- hitY  out  Y_WIDTH  y of the first hit in raster order.
- hitCount  out  X_WIDTH+Y_WIDTH+1  number of non-background pixels, saturating.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - done=1.
  - rdEn=0, rdX=0, rdY=0.
  - hit=0, hitX=0, hitY=0, hitCount=0.
  - Valid pipeline cleared.
- Bounds are sampled only on the start cycle. Later changes on the bound inputs are ignored until the next start.
- States:
  - IDLE: done=1.
  - start -> SCAN.
  - In SCAN, if lowerX>upperX or lowerY>upperY (empty region), go directly to DONE the cycle after start with hit=0 and hitCount=0.
  - In SCAN, rdEn=1 every cycle, starting the cycle after start. (rdX,rdY) begins at (lowerX,lowerY).
    - x advances each cycle.
    - When x==upperX, x reloads lowerX and y increments.
    - The equality compare comes before the increment, so upperX=2^X_WIDTH-1 and upperY=2^Y_WIDTH-1 scan correctly with no wrap.
  - After (upperX,upperY) is issued -> DRAIN.
  - DRAIN: rdEn=0 for READ_LATENCY cycles, then -> DONE.
  - DONE: done=1, results held, rdX=rdY=0, rdEn=0. Behaves as IDLE for start.
- Timing: with start sampled at edge k and region size N, rdEn is high for cycles k+1..k+N. The last data returns at k+N+READ_LATENCY. done rises at k+N+READ_LATENCY+1.
- Data tracking:
  - A READ_LATENCY-deep shift register carries {valid, x, y} alongside each read.
  - When a valid return has rdColour != BG_COLOUR: hitCount increments, saturating at all-ones.
  - If hit was 0 at that point, hit<=1 and hitX/hitY capture the tracked coordinate.
- On start, in any state:
  - done<=0.
  - hit, hitX, hitY and hitCount cleared.
  - Valid pipeline flushed, so in-flight returns from an aborted scan are discarded.
  - New bounds latched and the scan restarts.
- Reset mid-scan returns to reset values immediately. No partial result is retained.
- All outputs are registered.

Decomposition:
- Shared package `game_pkg`:
  - Localparams X_WIDTH, Y_WIDTH, COLOUR_WIDTH.
  - BG_COLOUR constant.
  - Screen extents 160x120.
  - State encoding IDLE/SCAN/DRAIN/DONE.
- One natural sub-module: `raster_counter`, the bounded x/y raster address generator with load and advance inputs and a last flag.
- The pixel-write side should reuse `raster_counter` later.

Test Plan:
- Empty RAM, bounds x 10..13, y 5..6, READ_LATENCY=1, start:
  - rdEn high exactly 8 cycles, addresses (10,5)..(13,5),(10,6)..(13,6).
  - done high 10 cycles after start.
  - hit=0, hitCount=0.
- RAM with colour 3'b100 at (12,5) and (11,6), same bounds:
  - hit=1, hitX=12, hitY=5, hitCount=2.
- Bounds x 255..255, y 127..127, colour 3'b001 there:
  - one read at (255,127), no wrap.
  - hit=1, hitCount=1.
  - done at start+3.
- lowerX=20, upperX=19:
  - rdEn never asserts.
  - done rises the cycle after start with hitCount=0.
- Start at region 0..7 x 0..0; second start at cycle k+4 with region 40..41 x 9..9, pixel at (3,0) nonzero:
  - old returns discarded.
  - final hitCount reflects only (40..41,9).
  - READ_LATENCY=2 variant: done at second start+2+2+1.
- Assert reset_n low mid-SCAN:
  - done=1, rdEn=0, hit=0, hitCount=0 asynchronously.
  - A new start after release scans normally.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game-side constants: coordinate/colour widths, background colour,
// screen extents and the region scanner state encoding.
package game_pkg;

    localparam int X_WIDTH      = 8;
    localparam int Y_WIDTH      = 7;
    localparam int COLOUR_WIDTH = 3;

    localparam logic [COLOUR_WIDTH-1:0] BG_COLOUR = '0;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/raster_counter.sv
// Bounded x/y raster address generator: load seeds the bounds and the start
// corner, advance steps in raster order, last flags the bottom-right corner.
module raster_counter #(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          clr_i,
    input  logic          adv_i,
    input  logic [XW-1:0] lo_x_i,
    input  logic [XW-1:0] hi_x_i,
    input  logic [YW-1:0] lo_y_i,
    input  logic [YW-1:0] hi_y_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [XW-1:0] lo_x_q, lo_x_d;
    logic [XW-1:0] hi_x_q, hi_x_d;
    logic [YW-1:0] hi_y_q, hi_y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            lo_x_q <= '0;
            hi_x_q <= '0;
            hi_y_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            lo_x_q <= lo_x_d;
            hi_x_q <= hi_x_d;
            hi_y_q <= hi_y_d;
        end
    end

    // Compare against the upper bound before incrementing so all-ones bounds never wrap.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        lo_x_d = lo_x_q;
        hi_x_d = hi_x_q;
        hi_y_d = hi_y_q;
        if (load_i) begin
            x_d    = lo_x_i;
            y_d    = lo_y_i;
            lo_x_d = lo_x_i;
            hi_x_d = hi_x_i;
            hi_y_d = hi_y_i;
        end else if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (adv_i) begin
            if (x_q == hi_x_q) begin
                x_d = lo_x_q;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == hi_x_q) && (y_q == hi_y_q);

endmodule

// File: rtl/region_scanner.sv
// Scans a rectangle of the shadow framebuffer one read per cycle and reports
// first non-background pixel and the saturating count of such pixels.
module region_scanner #(
    parameter int X_WIDTH      = game_pkg::X_WIDTH,
    parameter int Y_WIDTH      = game_pkg::Y_WIDTH,
    parameter int COLOUR_WIDTH = game_pkg::COLOUR_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter logic [COLOUR_WIDTH-1:0] BG_COLOUR = game_pkg::BG_COLOUR
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [X_WIDTH-1:0]       lowerXBound,
    input  logic [X_WIDTH-1:0]       upperXBound,
    input  logic [Y_WIDTH-1:0]       lowerYBound,
    input  logic [Y_WIDTH-1:0]       upperYBound,
    output logic [X_WIDTH-1:0]       rdX,
    output logic [Y_WIDTH-1:0]       rdY,
    output logic                     rdEn,
    input  logic [COLOUR_WIDTH-1:0]  rdColour,
    output logic                     done,
    output logic                     hit,
    output logic [X_WIDTH-1:0]       hitX,
    output logic [Y_WIDTH-1:0]       hitY,
    output logic [X_WIDTH+Y_WIDTH:0] hitCount
);

    import game_pkg::*;

    localparam int CW = X_WIDTH + Y_WIDTH + 1;
    localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);

    scan_state_e         state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic                done_q, done_d;
    logic                empty_q, empty_d;
    logic [1:0]          drain_q, drain_d;
    logic                hit_q, hit_d;
    logic [X_WIDTH-1:0]  hit_x_q, hit_x_d;
    logic [Y_WIDTH-1:0]  hit_y_q, hit_y_d;
    logic [CW-1:0]       hit_cnt_q, hit_cnt_d;

    logic                ctr_load, ctr_clr, ctr_adv, ctr_last;
    logic                start_empty;

    logic                pipe_v_q [READ_LATENCY];
    logic [X_WIDTH-1:0]  pipe_x_q [READ_LATENCY];
    logic [Y_WIDTH-1:0]  pipe_y_q [READ_LATENCY];

    raster_counter #(
        .XW (X_WIDTH),
        .YW (Y_WIDTH)
    ) u_raster (
        .clk    (clock),
        .rst_n  (reset_n),
        .load_i (ctr_load),
        .clr_i  (ctr_clr),
        .adv_i  (ctr_adv),
        .lo_x_i (lowerXBound),
        .hi_x_i (upperXBound),
        .lo_y_i (lowerYBound),
        .hi_y_i (upperYBound),
        .x_o    (rdX),
        .y_o    (rdY),
        .last_o (ctr_last)
    );

    assign start_empty = (lowerXBound > upperXBound) || (lowerYBound > upperYBound);

    // Coordinates travel with each read so returns can be attributed; start kills in-flight entries.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_v_q[i] <= 1'b0;
                pipe_x_q[i] <= '0;
                pipe_y_q[i] <= '0;
            end
        end else begin
            pipe_v_q[0] <= rd_en_q & ~start;
            pipe_x_q[0] <= rdX;
            pipe_y_q[0] <= rdY;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v_q[i] <= pipe_v_q[i-1] & ~start;
                pipe_x_q[i] <= pipe_x_q[i-1];
                pipe_y_q[i] <= pipe_y_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rd_en_q   <= 1'b0;
            done_q    <= 1'b1;
            empty_q   <= 1'b0;
            drain_q   <= '0;
            hit_q     <= 1'b0;
            hit_x_q   <= '0;
            hit_y_q   <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            done_q    <= done_d;
            empty_q   <= empty_d;
            drain_q   <= drain_d;
            hit_q     <= hit_d;
            hit_x_q   <= hit_x_d;
            hit_y_q   <= hit_y_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        done_d    = done_q;
        empty_d   = empty_q;
        drain_d   = drain_q;
        hit_d     = hit_q;
        hit_x_d   = hit_x_q;
        hit_y_d   = hit_y_q;
        hit_cnt_d = hit_cnt_q;
        ctr_load  = 1'b0;
        ctr_clr   = 1'b0;
        ctr_adv   = 1'b0;

        if (start) begin
            state_d   = ST_SCAN;
            ctr_load  = 1'b1;
            empty_d   = start_empty;
            rd_en_d   = ~start_empty;
            done_d    = 1'b0;
            drain_d   = '0;
            hit_d     = 1'b0;
            hit_x_d   = '0;
            hit_y_d   = '0;
            hit_cnt_d = '0;
        end else begin
            if (pipe_v_q[READ_LATENCY-1] && (rdColour != BG_COLOUR)) begin
                if (hit_cnt_q != '1) begin
                    hit_cnt_d = hit_cnt_q + CW'(1);
                end
                if (!hit_q) begin
                    hit_d   = 1'b1;
                    hit_x_d = pipe_x_q[READ_LATENCY-1];
                    hit_y_d = pipe_y_q[READ_LATENCY-1];
                end
            end

            case (state_q)
                ST_SCAN: begin
                    if (empty_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        ctr_clr = 1'b1;
                    end else if (ctr_last) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                        ctr_clr = 1'b1;
                    end else begin
                        ctr_adv = 1'b1;
                        rd_en_d = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        drain_d = drain_q + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdEn     = rd_en_q;
    assign done     = done_q;
    assign hit      = hit_q;
    assign hitX     = hit_x_q;
    assign hitY     = hit_y_q;
    assign hitCount = hit_cnt_q;

endmodule

// File: tb/tb_region_scanner.sv
// Scoreboard bench: two scanners (read latency 1 and 2) share stimulus and a
// framebuffer model; expected reads and results are queued per instance.
module tb_region_scanner;

    localparam logic [2:0] BG = 3'd0;

    typedef struct packed {
        int         cyc;
        logic [7:0] x;
        logic [6:0] y;
    } rd_t;

    typedef struct packed {
        int          cyc;
        logic        hit;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [15:0] cnt;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start;
    logic [7:0]  lx_i, ux_i;
    logic [6:0]  ly_i, uy_i;
    logic [1:0]  rd_en_w, done_w, hit_w;
    logic [7:0]  rd_x_w  [2];
    logic [6:0]  rd_y_w  [2];
    logic [7:0]  hit_x_w [2];
    logic [6:0]  hit_y_w [2];
    logic [15:0] cnt_w   [2];
    logic [2:0]  rcol    [2];
    logic [2:0]  stage1;

    logic [2:0]  mem [256][128];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    rd_t  exp_rd  [2][$];
    res_t exp_res [2][$];
    logic [1:0] prev_done = 2'b11;

    always @(posedge clk) cyc <= cyc + 1;

    // Framebuffer read ports: one cycle and two cycle latency.
    always @(posedge clk) begin
        rcol[0] <= mem[rd_x_w[0]][rd_y_w[0]];
        stage1  <= mem[rd_x_w[1]][rd_y_w[1]];
        rcol[1] <= stage1;
    end

    region_scanner #(.READ_LATENCY(1)) u_dut1 (
        .clock(clk), .reset_n(reset_n), .start(start),
        .lowerXBound(lx_i), .upperXBound(ux_i), .lowerYBound(ly_i), .upperYBound(uy_i),
        .rdX(rd_x_w[0]), .rdY(rd_y_w[0]), .rdEn(rd_en_w[0]), .rdColour(rcol[0]),
        .done(done_w[0]), .hit(hit_w[0]), .hitX(hit_x_w[0]), .hitY(hit_y_w[0]),
        .hitCount(cnt_w[0])
    );

    region_scanner #(.READ_LATENCY(2)) u_dut2 (
        .clock(clk), .reset_n(reset_n), .start(start),
        .lowerXBound(lx_i), .upperXBound(ux_i), .lowerYBound(ly_i), .upperYBound(uy_i),
        .rdX(rd_x_w[1]), .rdY(rd_y_w[1]), .rdEn(rd_en_w[1]), .rdColour(rcol[1]),
        .done(done_w[1]), .hit(hit_w[1]), .hitX(hit_x_w[1]), .hitY(hit_y_w[1]),
        .hitCount(cnt_w[1])
    );

    task automatic chk(input string name, input int d, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%0d required=%0d (cyc %0d)", name, d, act, req, cyc);
        end
    endtask

    // Reference: walk the rectangle in raster order over the framebuffer model.
    task automatic ref_scan(input int lx, input int ux, input int ly, input int uy, output res_t r);
        r = '0;
        for (int y = ly; y <= uy; y++) begin
            for (int x = lx; x <= ux; x++) begin
                if (mem[x][y] != BG) begin
                    if (!r.hit) begin
                        r.hit = 1'b1;
                        r.x   = 8'(x);
                        r.y   = 7'(y);
                    end
                    r.cnt = r.cnt + 16'd1;
                end
            end
        end
    endtask

    // Called just after a rising edge; start is sampled at the next edge.
    task automatic do_start(input int lx, input int ux, input int ly, input int uy);
        int   ks;
        int   n;
        int   i;
        bit   empty;
        res_t r;
        rd_t  e;
        ks    = cyc;
        empty = (lx > ux) || (ly > uy);
        n     = empty ? 0 : (ux - lx + 1) * (uy - ly + 1);
        ref_scan(lx, ux, ly, uy, r);
        for (int d = 0; d < 2; d++) begin
            while (exp_rd[d].size() > 0 && exp_rd[d][exp_rd[d].size()-1].cyc > ks)
                void'(exp_rd[d].pop_back());
            while (exp_res[d].size() > 0 && exp_res[d][exp_res[d].size()-1].cyc > ks)
                void'(exp_res[d].pop_back());
            i = 0;
            if (!empty) begin
                for (int y = ly; y <= uy; y++) begin
                    for (int x = lx; x <= ux; x++) begin
                        e.cyc = ks + 1 + i;
                        e.x   = 8'(x);
                        e.y   = 7'(y);
                        exp_rd[d].push_back(e);
                        i++;
                    end
                end
            end
            r.cyc = empty ? ks + 2 : ks + n + (d + 1) + 1;
            exp_res[d].push_back(r);
        end
        $display("START cyc=%0d x=%0d..%0d y=%0d..%0d expect hit=%0d at (%0d,%0d) count=%0d",
                 ks, lx, ux, ly, uy, r.hit, r.x, r.y, r.cnt);
        start = 1'b1;
        lx_i  = 8'(lx);
        ux_i  = 8'(ux);
        ly_i  = 7'(ly);
        uy_i  = 7'(uy);
        @(posedge clk);
        #1;
        start = 1'b0;
        lx_i  = 8'($urandom);
        ux_i  = 8'($urandom);
        ly_i  = 7'($urandom);
        uy_i  = 7'($urandom);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_res[0].size() > 0 || exp_res[1].size() > 0) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("pending_results", 0, exp_res[0].size() + exp_res[1].size(), 0);
        chk("pending_reads", 0, exp_rd[0].size() + exp_rd[1].size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_done"}, d, done_w[d], 1);
            chk({tag, "_rdEn"}, d, rd_en_w[d], 0);
            chk({tag, "_rdX"}, d, rd_x_w[d], 0);
            chk({tag, "_rdY"}, d, rd_y_w[d], 0);
            chk({tag, "_hit"}, d, hit_w[d], 0);
            chk({tag, "_hitX"}, d, hit_x_w[d], 0);
            chk({tag, "_hitY"}, d, hit_y_w[d], 0);
            chk({tag, "_hitCount"}, d, cnt_w[d], 0);
        end
        $display("RESET %s cyc=%0d checked", tag, cyc);
    endtask

    // Monitor: checks each issued read and each completed result on the falling edge.
    initial begin
        rd_t  e;
        res_t r;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!reset_n) begin
                    prev_done[d] = 1'b1;
                end else begin
                    if (rd_en_w[d]) begin
                        if (exp_rd[d].size() == 0) begin
                            chk("unexpected_read", d, 1, 0);
                        end else begin
                            e = exp_rd[d].pop_front();
                            chk("read_cycle", d, cyc, e.cyc);
                            chk("rdX", d, rd_x_w[d], e.x);
                            chk("rdY", d, rd_y_w[d], e.y);
                        end
                    end else if (exp_rd[d].size() > 0 && exp_rd[d][0].cyc <= cyc) begin
                        e = exp_rd[d].pop_front();
                        chk("missing_read_rdEn", d, 0, 1);
                    end
                    if (done_w[d] && !prev_done[d]) begin
                        if (exp_res[d].size() == 0) begin
                            chk("unexpected_done", d, 1, 0);
                        end else begin
                            r = exp_res[d].pop_front();
                            $display("DONE dut%0d cyc=%0d hit=%0d at (%0d,%0d) count=%0d",
                                     d, cyc, hit_w[d], hit_x_w[d], hit_y_w[d], cnt_w[d]);
                            chk("done_cycle", d, cyc, r.cyc);
                            chk("hit", d, hit_w[d], r.hit);
                            chk("hitX", d, hit_x_w[d], r.x);
                            chk("hitY", d, hit_y_w[d], r.y);
                            chk("hitCount", d, cnt_w[d], r.cnt);
                        end
                    end
                    prev_done[d] = done_w[d];
                end
            end
        end
    end

    initial begin
        int lx, ux, ly, uy, mode;
        reset_n = 1'b0;
        start   = 1'b0;
        lx_i = '0; ux_i = '0; ly_i = '0; uy_i = '0;
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++)
                mem[x][y] = BG;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("por");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Empty framebuffer, 4x2 region
        do_start(10, 13, 5, 6);
        wait_done();

        // Two hits in the same region
        mem[12][5] = 3'b100;
        mem[11][6] = 3'b100;
        do_start(10, 13, 5, 6);
        wait_done();

        // Single pixel at the far corner
        mem[255][127] = 3'b001;
        do_start(255, 255, 127, 127);
        wait_done();

        // Inverted x bounds: no reads
        do_start(20, 19, 0, 5);
        wait_done();

        // Restart mid-scan discards returns from the aborted scan
        mem[3][0]  = 3'd5;
        mem[41][9] = 3'd2;
        do_start(0, 7, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        do_start(40, 41, 9, 9);
        wait_done();

        // Reset in the middle of a scan that already has a hit
        mem[0][0] = 3'd6;
        do_start(0, 15, 0, 3);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_rd[d].delete();
            exp_res[d].delete();
        end
        #1;
        chk_reset_state("midscan");
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_start(0, 15, 0, 3);
        wait_done();

        // Randomised regions over a sparse random framebuffer
        for (int it = 0; it < 30; it++) begin
            for (int x = 0; x < 256; x++)
                for (int y = 0; y < 128; y++)
                    mem[x][y] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : BG;
            mode = $urandom_range(0, 7);
            lx = $urandom_range(0, 60);
            ux = lx + $urandom_range(0, 12);
            ly = $urandom_range(0, 30);
            uy = ly + $urandom_range(0, 5);
            if (mode == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    lx = $urandom_range(1, 200);
                    ux = lx - 1;
                end else begin
                    ly = $urandom_range(1, 100);
                    uy = ly - 1;
                end
            end else if (mode == 1) begin
                lx = $urandom_range(244, 255);
                ux = 255;
                ly = $urandom_range(122, 127);
                uy = 127;
            end
            if (mode >= 6) begin
                do_start(lx, lx + 5 + $urandom_range(0, 7), ly, ly + $urandom_range(0, 3));
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
            do_start(lx, ux, ly, uy);
            wait_done();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
